bus_master_seq: RTL and testbench

//  Synthesizable CPU-side bus master that turns queued read/write requests into
//  ce/rd/wr/addr/data_wr bus cycles for the memory/slave stage downstream.

---
 rtl/bus_master_seq.sv | 143 ++++++++++++++
 tb/tb_bus_master_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_seq.sv
// Queued CPU-side bus master: buffers read/write requests in a small FIFO and
// runs each as a ce/rd/wr bus cycle, waiting for bus_ack with a timeout.
module bus_master_seq #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_wr,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          bus_ce,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_data_wr,
  input  logic [DW-1:0] bus_data_rd,
  input  logic          bus_ack
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + DW;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Entry layout: {wr, addr, wdata}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    state_reg;
  logic [7:0]    tcnt_reg;
  logic          cur_wr_reg;

  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          head_wr;

  assign req_ready = (count_reg != DEPTH_C);
  assign push      = req_valid && req_ready;
  assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_wr   = head[EW-1];
  assign busy      = (state_reg != ST_IDLE) || (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_wr, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      tcnt_reg    <= '0;
      cur_wr_reg  <= 1'b0;
      bus_ce      <= 1'b0;
      bus_rd      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_addr    <= '0;
      bus_data_wr <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      // Response fields default low so the pulse lasts exactly one cycle.
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            bus_ce      <= 1'b1;
            bus_rd      <= !head_wr;
            bus_wr      <= head_wr;
            bus_addr    <= head[AW+DW-1:DW];
            bus_data_wr <= head_wr ? head[DW-1:0] : '0;
            cur_wr_reg  <= head_wr;
            tcnt_reg    <= '0;
            state_reg   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (bus_ack || (tcnt_reg + 8'd1 == TIMEOUT_C)) begin
            rsp_valid   <= 1'b1;
            rsp_wr      <= cur_wr_reg;
            rsp_err     <= !bus_ack;
            rsp_rdata   <= (bus_ack && !cur_wr_reg) ? bus_data_rd : '0;
            bus_ce      <= 1'b0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= '0;
            bus_data_wr <= '0;
            state_reg   <= ST_RESP;
          end else begin
            tcnt_reg <= tcnt_reg + 8'd1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq: slave model with programmable ack delay,
// scoreboard queues for bus cycles and responses.
module tb_bus_master_seq;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_wr;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       bus_ce;
  logic       bus_rd;
  logic       bus_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_data_wr;
  logic [7:0] bus_data_rd;
  logic       bus_ack;

  bus_master_seq #(.AW(8), .DW(8), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .bus_ce(bus_ce), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_data_wr(bus_data_wr), .bus_data_rd(bus_data_rd), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 1;
  int ce_cnt = 0;
  int ce_run = 0;
  int last_ce_len = 0;

  logic [7:0] slave_mem [256];
  logic [7:0] ref_mem [256];
  logic [9:0]  exp_rsp [$];   // {wr, err, rdata}
  logic [16:0] exp_bus [$];   // {wr, addr, wdata}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave: acks on the ack_delay-th cycle of bus_ce (never when ack_delay is 0).
  always @(negedge clk) begin
    if (bus_ce) begin
      ce_cnt = ce_cnt + 1;
      if (ack_delay != 0 && ce_cnt == ack_delay) begin
        bus_ack = 1'b1;
        bus_data_rd = slave_mem[bus_addr];
        if (bus_wr) slave_mem[bus_addr] = bus_data_wr;
      end else begin
        bus_ack = 1'b0;
        bus_data_rd = 8'hEE;
      end
    end else begin
      ce_cnt = 0;
      bus_ack = 1'b0;
      bus_data_rd = 8'hEE;
    end
  end

  // Monitor: bus cycle contents on ce rise, ce length on fall, responses.
  always @(negedge clk) begin
    if (bus_ce) begin
      if (ce_run == 0) begin
        if (exp_bus.size() == 0) check("bus_unexp", 1, 0);
        else check("bus_op", {12'd0, bus_rd, bus_wr, bus_addr, bus_data_wr},
                   {12'd0, ~exp_bus[0][16], exp_bus.pop_front()});
      end
      ce_run = ce_run + 1;
    end else if (ce_run != 0) begin
      last_ce_len = ce_run;
      ce_run = 0;
    end
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) check("rsp_unexp", 1, 0);
      else check("rsp", {rsp_wr, rsp_err, rsp_rdata}, exp_rsp.pop_front());
    end else if (rsp_wr || rsp_err || rsp_rdata != 8'h00) begin
      check("rsp_idle_zero", {rsp_wr, rsp_err, rsp_rdata}, 0);
    end
  end

  task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      input logic exp_err);
    logic ok;
    logic [7:0] rd;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) check("push_ready_timeout", 0, 1);
    rd = 8'h00;
    if (wr) ref_mem[addr] = data;
    else if (!exp_err) rd = ref_mem[addr];
    exp_rsp.push_back({wr, exp_err, rd});
    exp_bus.push_back({wr, addr, wr ? data : 8'h00});
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !busy && !rsp_valid && exp_rsp.size() == 0;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_ce();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus_ce;
    end
    if (!done) check("ce_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i]   = 8'(i) ^ 8'h3C;
    end
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    bus_ack = 1'b0; bus_data_rd = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_bus_ce", bus_ce, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    reset = 1'b0;

    // 1: write with one-cycle ack, latency profile
    ack_delay = 1;
    push(1'b1, 8'h11, 8'hAA, 1'b0);
    @(negedge clk); check("lat_ce_e0", bus_ce, 0);
    @(negedge clk); check("lat_ce_e1", bus_ce, 1);
    @(negedge clk); check("lat_rsp_e2", {rsp_valid, bus_ce}, 2'b10);
    @(negedge clk); check("lat_rsp_e3", rsp_valid, 0);
    wait_idle();
    check("t1_ce_len", last_ce_len, 1);

    // 2: read back with three-cycle ack
    ack_delay = 3;
    push(1'b0, 8'h11, 8'h00, 1'b0);
    wait_idle();
    check("t2_ce_len", last_ce_len, 3);

    // 3: blocker access keeps FIFO from draining while five requests arrive
    ack_delay = 10;
    push(1'b0, 8'h50, 8'h00, 1'b0);
    wait_ce();
    push(1'b1, 8'h20, 8'h01, 1'b0);
    push(1'b0, 8'h11, 8'h00, 1'b0);
    push(1'b1, 8'h21, 8'h02, 1'b0);
    push(1'b0, 8'h20, 8'h00, 1'b0);
    @(negedge clk); check("t3_full_ready", req_ready, 0);
    check("t3_busy", busy, 1);
    push(1'b0, 8'h21, 8'h00, 1'b0);
    wait_idle();

    // 4: no ack -> timeout, then the next request still runs
    ack_delay = 0;
    push(1'b0, 8'h30, 8'h00, 1'b1);
    wait_idle();
    check("t4_ce_len", last_ce_len, 15);
    check("t4_bus_idle", {bus_ce, bus_rd, bus_wr, bus_addr}, 0);
    ack_delay = 2;
    push(1'b0, 8'h20, 8'h00, 1'b0);
    wait_idle();

    // 5: ack on the timeout edge wins
    ack_delay = 15;
    push(1'b0, 8'h11, 8'h00, 1'b0);
    wait_idle();
    check("t5_ce_len", last_ce_len, 15);

    // 6: reset in the middle of an access with another request queued
    ack_delay = 0;
    push(1'b0, 8'h40, 8'h00, 1'b0);
    push(1'b1, 8'h41, 8'h99, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    exp_rsp.delete();
    exp_bus.delete();
    #1;
    check("t6_bus", {bus_ce, bus_rd, bus_wr, bus_addr, bus_data_wr}, 0);
    check("t6_rsp", {rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_still_idle", {busy, bus_ce}, 0);
    ack_delay = 1;
    push(1'b1, 8'h42, 8'h77, 1'b0);
    push(1'b0, 8'h42, 8'h00, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
